// File: rtl/bram_sdp.sv
// -----------------------------------------------------------------------------
// bram_sdp
//
// Parametrised simple-dual-port block RAM with a hardware clear sequencer.
// One synchronous write port and one synchronous read port share a single
// clock. After reset, or on request through io_clear, an internal sweep
// writes CLEAR_VAL to every address, so contents are always defined before
// the ports are opened to traffic.
//
// Parameters
//   DATA_W     data width in bits (1..64)
//   ADDR_W     address width, DEPTH = 2^ADDR_W words
//   RDW_MODE   same-address read-during-write: 0 = old data, 1 = new data
//   OUT_REG    1 adds an output register stage (read latency 2 instead of 1)
//   CLEAR_VAL  fill value written by the clear sweep
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   io_wr_en     write strobe
//   io_wr_addr   write address
//   io_wr_data   write data
//   io_rd_en     read strobe
//   io_rd_addr   read address
//   io_clear     request a full clear sweep (pulse or level)
//   io_rd_data   read data, qualified by io_rd_valid, held between reads
//   io_rd_valid  high for one cycle per accepted read
//   io_ready     high while the ports accept traffic (IDLE state)
// -----------------------------------------------------------------------------
module bram_sdp #(
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 4,
    parameter int                RDW_MODE  = 0,
    parameter int                OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_wr_en,
    input  logic [ADDR_W-1:0] io_wr_addr,
    input  logic [DATA_W-1:0] io_wr_data,
    input  logic              io_rd_en,
    input  logic [ADDR_W-1:0] io_rd_addr,
    input  logic              io_clear,
    output logic [DATA_W-1:0] io_rd_data,
    output logic              io_rd_valid,
    output logic              io_ready
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // One bit wider than the address so the sweep can never alias back
    // onto address 0 before the FSM leaves CLEAR.
    logic [ADDR_W:0] sweep_cnt;
    logic [ADDR_W:0] next_sweep_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              wr_accept;
    logic              rd_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // A clear request in IDLE takes priority: any write or read presented
    // in the same cycle is dropped rather than racing the sweep.
    assign ready     = (state == ST_IDLE);
    assign wr_accept = ready & io_wr_en & ~io_clear;
    assign rd_accept = ready & io_rd_en & ~io_clear;
    assign io_ready  = ready;

    // State and sweep counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
        end else begin
            state     <= next_state;
            sweep_cnt <= next_sweep_cnt;
        end
    end

    // Next-state logic. The sweep writes one address per cycle and leaves
    // CLEAR together with the write of the last address. A clear request
    // seen while already sweeping is ignored so the sweep length is fixed.
    always_comb begin
        next_state     = state;
        next_sweep_cnt = sweep_cnt;
        case (state)
            ST_CLEAR: begin
                if (sweep_cnt == LAST_ADDR) begin
                    next_state     = ST_IDLE;
                    next_sweep_cnt = '0;
                end else begin
                    next_sweep_cnt = sweep_cnt + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (io_clear) begin
                    next_state     = ST_CLEAR;
                    next_sweep_cnt = '0;
                end
            end
            default: begin
                next_state     = ST_CLEAR;
                next_sweep_cnt = '0;
            end
        endcase
    end

    // Write-port mux: the sweep owns the write port for the whole of CLEAR,
    // user writes only reach the array from IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = io_wr_addr;
        mem_wdata = io_wr_data;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_cnt[ADDR_W-1:0];
            mem_wdata = CLEAR_VAL;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    // The storage array has no reset so it maps onto block RAM; its
    // contents are defined purely by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Same-address read-during-write selection. Read-first simply samples
    // the array before the write lands; write-first forwards the incoming
    // write data around the array.
    generate
        if (RDW_MODE == 1) begin : g_write_first
            assign rd_word = (wr_accept && (io_wr_addr == io_rd_addr))
                           ? io_wr_data : mem[io_rd_addr];
        end else begin : g_read_first
            assign rd_word = mem[io_rd_addr];
        end
    endgenerate

    // First read stage. Data only updates on an accepted read so the last
    // value stays visible after io_rd_valid falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= rd_word;
            end
        end
    end

    // Optional output register stage, with the same hold behaviour.
    generate
        if (OUT_REG == 1) begin : g_out_reg
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign io_rd_data  = s2_data;
            assign io_rd_valid = s2_valid;
        end else begin : g_no_out_reg
            assign io_rd_data  = s1_data;
            assign io_rd_valid = s1_valid;
        end
    endgenerate

endmodule
